// File: rtl/cw_sequencer.sv
// -----------------------------------------------------------------------------
// cw_sequencer
//
// Consuming end of the 33-bit control word for the multi-cycle CPU. Holds the
// instruction register, the 2-bit micro-state and the 5-bit status register
// that the instruction decoders read. It runs the fetch cycle on its own and,
// during execution, unpacks the decoder's control word into datapath strobes.
// Memory stalls hold all sequencing state; next_state decides whether the
// instruction continues or returns to fetch.
//
// Handshake: a RAM access is requested by ram_en and completes in the cycle
// mem_ready is high. While ram_en=1 and mem_ready=0 the request stays stable,
// no architectural state advances and the PC and register file are not
// written.
//
// Ports
//   clock      in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high
//   data_bus   in  64  shared data bus, instruction taken from [31:0]
//   mem_ready  in   1  RAM access completes this cycle
//   cw_in      in  33  control word from the selected decoder
//   k_in       in  64  immediate constant from the selected decoder
//   status_in  in   5  ALU status flags
//   I          out 32  instruction register
//   state      out  2  micro-state fed to the decoders
//   status     out  5  status register
//   fetch      out  1  high while in the fetch phase (phase debug view)
//   alu_en, alu_bs, alu_fs, rf_b_en, rf_sa, rf_sb, rf_da, rf_w,
//   ram_en, ram_w, pc_en, pc_fs, pc_is, K      datapath strobes and constant
// -----------------------------------------------------------------------------
module cw_sequencer #(
    parameter logic [1:0] FETCH_PC_FS = 2'b01
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] data_bus,
    input  logic        mem_ready,
    input  logic [32:0] cw_in,
    input  logic [63:0] k_in,
    input  logic [4:0]  status_in,
    output logic [31:0] I,
    output logic [1:0]  state,
    output logic [4:0]  status,
    output logic        fetch,
    output logic        alu_en,
    output logic        alu_bs,
    output logic [4:0]  alu_fs,
    output logic        rf_b_en,
    output logic [4:0]  rf_sa,
    output logic [4:0]  rf_sb,
    output logic [4:0]  rf_da,
    output logic        rf_w,
    output logic        ram_en,
    output logic        ram_w,
    output logic        pc_en,
    output logic [1:0]  pc_fs,
    output logic        pc_is,
    output logic [63:0] K
);

    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_t;

    phase_t      r_phase;
    logic [31:0] r_ir;
    logic [1:0]  r_state;
    logic [4:0]  r_status;

    phase_t      w_phase_next;
    logic [31:0] w_ir_next;
    logic [1:0]  w_state_next;
    logic [4:0]  w_status_next;

    // Control word fields
    logic        w_cw_alu_en;
    logic        w_cw_alu_bs;
    logic [4:0]  w_cw_alu_fs;
    logic        w_cw_rf_b_en;
    logic [4:0]  w_cw_rf_sa;
    logic [4:0]  w_cw_rf_sb;
    logic [4:0]  w_cw_rf_da;
    logic        w_cw_rf_w;
    logic        w_cw_ram_en;
    logic        w_cw_ram_w;
    logic        w_cw_pc_en;
    logic [1:0]  w_cw_pc_fs;
    logic        w_cw_pc_is;
    logic        w_cw_status_ld;
    logic [1:0]  w_cw_next_state;

    logic        w_stall;
    logic        w_unused;

    assign w_cw_alu_en     = cw_in[32];
    assign w_cw_alu_bs     = cw_in[31];
    assign w_cw_alu_fs     = cw_in[30:26];
    assign w_cw_rf_b_en    = cw_in[25];
    assign w_cw_rf_sa      = cw_in[24:20];
    assign w_cw_rf_sb      = cw_in[19:15];
    assign w_cw_rf_da      = cw_in[14:10];
    assign w_cw_rf_w       = cw_in[9];
    assign w_cw_ram_en     = cw_in[8];
    assign w_cw_ram_w      = cw_in[7];
    assign w_cw_pc_en      = cw_in[6];
    assign w_cw_pc_fs      = cw_in[5:4];
    assign w_cw_pc_is      = cw_in[3];
    assign w_cw_status_ld  = cw_in[2];
    assign w_cw_next_state = cw_in[1:0];

    // Only meaningful in EXEC; fetch stalls are handled in the FETCH branch.
    assign w_stall = w_cw_ram_en & ~mem_ready;

    // Upper half of the bus carries data, never instruction bits.
    assign w_unused = ^data_bus[63:32];

    assign I      = r_ir;
    assign state  = r_state;
    assign status = r_status;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase  <= PH_FETCH;
            r_ir     <= 32'd0;
            r_state  <= 2'b00;
            r_status <= 5'd0;
        end else begin
            r_phase  <= w_phase_next;
            r_ir     <= w_ir_next;
            r_state  <= w_state_next;
            r_status <= w_status_next;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        w_phase_next  = r_phase;
        w_ir_next     = r_ir;
        w_state_next  = r_state;
        w_status_next = r_status;
        case (r_phase)
            PH_FETCH: begin
                if (mem_ready) begin
                    w_ir_next    = data_bus[31:0];
                    w_state_next = 2'b00;
                    w_phase_next = PH_EXEC;
                end
            end
            PH_EXEC: begin
                if (!w_stall) begin
                    if (w_cw_status_ld) begin
                        w_status_next = status_in;
                    end
                    if (w_cw_next_state == 2'b00) begin
                        w_phase_next = PH_FETCH;
                        w_state_next = 2'b00;
                    end else begin
                        w_state_next = w_cw_next_state;
                    end
                end
            end
            default: begin
                w_phase_next = PH_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        fetch   = (r_phase == PH_FETCH);
        alu_en  = 1'b0;
        alu_bs  = 1'b0;
        alu_fs  = 5'd0;
        rf_b_en = 1'b0;
        rf_sa   = 5'd0;
        rf_sb   = 5'd0;
        rf_da   = 5'd0;
        rf_w    = 1'b0;
        ram_en  = 1'b0;
        ram_w   = 1'b0;
        pc_en   = 1'b0;
        pc_fs   = 2'b00;
        pc_is   = 1'b0;
        K       = 64'd0;
        if (r_phase == PH_FETCH) begin
            ram_en = 1'b1;
            alu_fs = 5'b11111;
            // PC advances only when the instruction actually arrives.
            pc_fs  = mem_ready ? FETCH_PC_FS : 2'b00;
        end else begin
            alu_en  = w_cw_alu_en;
            alu_bs  = w_cw_alu_bs;
            alu_fs  = w_cw_alu_fs;
            rf_b_en = w_cw_rf_b_en;
            rf_sa   = w_cw_rf_sa;
            rf_sb   = w_cw_rf_sb;
            rf_da   = w_cw_rf_da;
            rf_w    = w_cw_rf_w;
            ram_en  = w_cw_ram_en;
            ram_w   = w_cw_ram_w;
            pc_en   = w_cw_pc_en;
            pc_fs   = w_cw_pc_fs;
            pc_is   = w_cw_pc_is;
            K       = k_in;
            // Stalled: keep the memory request stable, suppress commits.
            if (w_stall) begin
                rf_w  = 1'b0;
                pc_fs = 2'b00;
            end
        end
        // No writes escape while reset is asserted, whatever the phase.
        if (reset) begin
            rf_w  = 1'b0;
            ram_w = 1'b0;
            pc_fs = 2'b00;
        end
    end

endmodule
